wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the async FIFO, parametrised in address width. It keeps the binary and Gray write pointers, with one extra wrap bit beyond the address width. It generates the memory write strobe and address, and derives full, programmable almost_full, fill level and a sticky overflow flag. All status comes from the read pointer after it has been synchronised into wclk. Sits between the write client, the dual-port RAM write port and the rptr-to-wclk synchroniser.

Parameters:
ADDR_WIDTH, 3, RAM address bits; DEPTH = 2**ADDR_WIDTH; legal range 2..16.
PTR_WIDTH, ADDR_WIDTH+1, pointer width including wrap bit; derived, not overridable.

Ports:
wclk  in  1  write-domain clock; all state updates on its rising edge.
wrst  in  1  synchronous reset, active-high.
w_en  in  1  client write request.
g_rptr_sync  in  PTR_WIDTH  Gray read pointer, already synchronised into wclk.
afull_thresh  in  PTR_WIDTH  almost_full threshold in entries; sampled every cycle.
ovf_clr  in  1  clears overflow.
wr_accept  out  1  RAM write strobe (combinational).
waddr  out  ADDR_WIDTH  RAM write address; equals b_wptr[ADDR_WIDTH-1:0].
b_wptr  out  PTR_WIDTH  binary write pointer (registered).
g_wptr  out  PTR_WIDTH  Gray write pointer (registered); goes to the read-domain synchroniser.
full  out  1  FIFO full (registered).
almost_full  out  1  level >= afull_thresh (registered).
wlevel  out  PTR_WIDTH  occupancy as seen from wclk, 0..DEPTH (registered).
overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (wrst=1 at an edge): b_wptr=0, g_wptr=0, full=0, almost_full=0, wlevel=0, overflow=0.
  - Reset overrides all other inputs.
  - A reset asserted mid-stream discards the pointers with no drain.
- wr_accept = w_en & ~full & ~wrst. Purely combinational; the RAM writes at the same edge the pointer advances.
- b_next = b_wptr + wr_accept, modulo 2**PTR_WIDTH. The wrap from all-ones to 0 is natural; the MSB toggles once per DEPTH writes.
- g_next = b_next ^ (b_next >> 1). On each edge: b_wptr<=b_next, g_wptr<=g_next.
  - g_wptr changes in exactly one bit per accepted write, and never changes without an accept.
- Full compare, per edge:
  - full <= (g_next == {~g_rptr_sync[PTR_WIDTH-1:PTR_WIDTH-2], g_rptr_sync[PTR_WIDTH-3:0]}).
  - full therefore asserts on the edge of the DEPTH-th outstanding write. No write is ever accepted while full=1, so there is no overshoot.
- Read-pointer conversion: rbin = Gray-to-binary of g_rptr_sync, an XOR prefix from the MSB down; combinational.
- Level and almost_full, per edge:
  - wlevel <= b_next - rbin (modulo 2**PTR_WIDTH); the result is always 0..DEPTH.
  - almost_full <= ((b_next - rbin) >= afull_thresh), unsigned compare.
  - afull_thresh=0 forces almost_full=1 after the first post-reset edge.
  - afull_thresh > DEPTH means almost_full never asserts.
- Pessimism: full, wlevel and almost_full lag reads by the synchroniser latency, so they over-report occupancy.
  - full deasserts on the first edge after g_rptr_sync advances.
  - It never deasserts early.
- overflow, per edge:
  - Set when w_en & full.
  - Cleared when ovf_clr.
  - Set wins if both occur in the same cycle; otherwise holds.
  - The rejected write does not move the pointer or touch the RAM.
- Simultaneous write and read-pointer advance in the same cycle: the compare uses b_next and the current g_rptr_sync, so wlevel stays unchanged and full does not assert.
- Consistency invariant: full==1 iff wlevel==DEPTH.
- g_rptr_sync is trusted to be a legal Gray code no more than DEPTH behind. No check is made.

Test Plan:
1. Reset then fill (ADDR_WIDTH=3), g_rptr_sync=0, w_en=1 for 10 cycles:
   - waddr runs 0..7 and wr_accept is high 8 cycles.
   - full=1 after the 8th write; wlevel=8; b_wptr=8 (4'b1000), g_wptr=4'b1100.
   - overflow=1 after the 9th attempt, and pointers are unchanged.
2. From full, set g_rptr_sync to Gray(1)=4'b0001:
   - Next edge: full=0, wlevel=7.
   - One more write: full=1, b_wptr=9, g_wptr=4'b1101.
3. Wrap-around: stream 40 writes with g_rptr_sync tracking b_wptr one cycle late:
   - Every g_wptr transition differs in exactly 1 bit.
   - b_wptr wraps from 15 to 0; full never asserts; wlevel<=1.
4. almost_full with afull_thresh=6:
   - Asserts on the edge where wlevel becomes 6; deasserts when a read drops wlevel to 5.
   - With afull_thresh=9 it never asserts.
5. overflow clear:
   - ovf_clr and a write-while-full in the same cycle -> overflow stays 1.
   - ovf_clr alone next cycle -> overflow=0.
6. Reset mid-stream at wlevel=5 with w_en=1:
   - Next edge: all outputs 0 and wr_accept=0 during reset.
   - The first write after release uses waddr=0.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - async FIFO write-side pointer, full/almost_full/level and overflow control
module wptr_full_ctrl #(
    parameter  int ADDR_WIDTH = 3,
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic [PTR_WIDTH-1:0]  g_rptr_sync,
    input  logic [PTR_WIDTH-1:0]  afull_thresh,
    input  logic                  ovf_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH-1:0]  b_wptr,
    output logic [PTR_WIDTH-1:0]  g_wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [PTR_WIDTH-1:0]  wlevel,
    output logic                  overflow
);

    logic [PTR_WIDTH-1:0] b_next;
    logic [PTR_WIDTH-1:0] g_next;
    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] level_next;
    logic [PTR_WIDTH-1:0] g_full_cmp;

    assign wr_accept = w_en & ~full & ~wrst;
    assign waddr     = b_wptr[ADDR_WIDTH-1:0];

    assign b_next = b_wptr + {{(PTR_WIDTH-1){1'b0}}, wr_accept};
    assign g_next = b_next ^ (b_next >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            rbin[i] = ^(g_rptr_sync >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign g_full_cmp = {~g_rptr_sync[PTR_WIDTH-1:PTR_WIDTH-2], g_rptr_sync[PTR_WIDTH-3:0]};
    assign level_next = b_next - rbin;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            full        <= (g_next == g_full_cmp);
            almost_full <= (level_next >= afull_thresh);
            wlevel      <= level_next;
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - scoreboard bench for wptr_full_ctrl against a write/read-count model
module tb_wptr_full_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          w_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [PW-1:0] g_rptr_sync = '0;
    logic [PW-1:0] afull_thresh = PW'(6);
    logic          wr_accept;
    logic [AW-1:0] waddr;
    logic [PW-1:0] b_wptr;
    logic [PW-1:0] g_wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wlevel;
    logic          overflow;

    wptr_full_ctrl #(.ADDR_WIDTH(AW)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .w_en        (w_en),
        .g_rptr_sync (g_rptr_sync),
        .afull_thresh(afull_thresh),
        .ovf_clr     (ovf_clr),
        .wr_accept   (wr_accept),
        .waddr       (waddr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic          acc;
        logic [AW-1:0] waddr;
        logic [PW-1:0] b;
        logic [PW-1:0] g;
        logic [PW-1:0] level;
        logic          full;
        logic          afull;
        logic          ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: total accepted writes and total reads exposed via g_rptr_sync.
    int   wcnt = 0;
    int   rcnt = 0;
    bit   mfull = 1'b0;
    bit   movf = 1'b0;

    function automatic logic [PW-1:0] gray(input int v);
        logic [31:0]   t;
        logic [PW-1:0] b;
        t = v;
        b = t[PW-1:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] wrapped(input int v);
        logic [31:0] t;
        t = v;
        return t[PW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit wen, input bit rd, input bit clr, input int thr);
        exp_t        e;
        int          occ;
        logic [31:0] wa;
        @(negedge wclk);
        if (rst) rcnt = 0;
        else if (rd && rcnt < wcnt) rcnt++;
        wrst         = rst;
        w_en         = wen;
        ovf_clr      = clr;
        afull_thresh = PW'(thr);
        g_rptr_sync  = gray(rcnt);
        wa           = wcnt % DEPTH;
        e.waddr      = wa[AW-1:0];
        if (rst) begin
            e.acc = 1'b0;
            wcnt  = 0;
            rcnt  = 0;
            mfull = 1'b0;
            movf  = 1'b0;
            occ   = 0;
            e.afull = 1'b0;
        end else begin
            e.acc = wen && !mfull;
            if (wen && mfull) movf = 1'b1;
            else if (clr) movf = 1'b0;
            wcnt  = wcnt + (e.acc ? 1 : 0);
            occ   = wcnt - rcnt;
            mfull = (occ == DEPTH);
            e.afull = (occ >= thr);
        end
        e.b     = wrapped(wcnt);
        e.g     = gray(wcnt);
        e.level = wrapped(occ);
        e.full  = mfull;
        e.ovf   = movf;
        q.push_back(e);
    endtask

    // Monitor: combinational outputs after the inputs settle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            #2;
            if (q.size() > 0) begin
                chk("wr_accept", 32'(wr_accept), 32'(q[0].acc));
                chk("waddr", 32'(waddr), 32'(q[0].waddr));
            end
            @(posedge wclk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("b_wptr", 32'(b_wptr), 32'(e.b));
                chk("g_wptr", 32'(g_wptr), 32'(e.g));
                chk("wlevel", 32'(wlevel), 32'(e.level));
                chk("full", 32'(full), 32'(e.full));
                chk("almost_full", 32'(almost_full), 32'(e.afull));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("full_vs_level", 32'(full), 32'(wlevel == PW'(DEPTH)));
            end
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 6);
        cycle(1, 1, 0, 0, 6);
        // Fill past full with the read pointer parked at 0.
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 6);
        // One read frees a slot, then refill and overflow again.
        cycle(0, 0, 1, 0, 6);
        cycle(0, 1, 0, 0, 6);
        cycle(0, 1, 0, 0, 6);
        // Clear racing a write-while-full, then clear alone.
        cycle(0, 1, 0, 1, 6);
        cycle(0, 0, 0, 1, 6);
        // Wrap-around with the read pointer tracking one cycle late.
        cycle(1, 0, 0, 0, 6);
        for (int i = 0; i < 40; i++) cycle(0, 1, 1, 0, 6);
        // almost_full at threshold 6, read drops it, then threshold 9 and 0.
        cycle(1, 0, 0, 0, 6);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 6);
        cycle(0, 0, 1, 0, 6);
        cycle(0, 0, 1, 0, 6);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 9);
        cycle(0, 0, 0, 0, 0);
        // Reset mid-stream with writes pending, then the first write after release.
        cycle(1, 0, 0, 0, 6);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 6);
        cycle(1, 1, 0, 0, 6);
        cycle(0, 1, 0, 0, 6);
        cycle(0, 1, 0, 0, 6);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, DEPTH + 2)));
        end
        cycle(0, 0, 0, 0, 6);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge wclk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
